// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - default timing and polarity constants for the video timing generator
package video_timing_pkg;

`include "video_timing_defs.vh"

   localparam int DEF_H_DISPLAY = `VTG_H_DISPLAY;
   localparam int DEF_H_FRONT   = `VTG_H_FRONT;
   localparam int DEF_H_SYNC    = `VTG_H_SYNC;
   localparam int DEF_H_BACK    = `VTG_H_BACK;
   localparam int DEF_H_TOTAL   = `VTG_TOTAL(`VTG_H_DISPLAY, `VTG_H_FRONT, `VTG_H_SYNC, `VTG_H_BACK);

   localparam int DEF_V_DISPLAY = `VTG_V_DISPLAY;
   localparam int DEF_V_BOTTOM  = `VTG_V_BOTTOM;
   localparam int DEF_V_SYNC    = `VTG_V_SYNC;
   localparam int DEF_V_TOP     = `VTG_V_TOP;
   localparam int DEF_V_TOTAL   = `VTG_TOTAL(`VTG_V_DISPLAY, `VTG_V_BOTTOM, `VTG_V_SYNC, `VTG_V_TOP);

   localparam bit DEF_H_SYNC_POL = 1'b1;
   localparam bit DEF_V_SYNC_POL = 1'b1;

endpackage

// File: rtl/video_timing_axis.sv
// rtl/video_timing_axis.sv - one timing axis: position counter, active config and region decode
// sync_next/visible_next describe the position the counter moves to on this edge.
module video_timing_axis
   import video_timing_pkg::*;
#(
   parameter int W       = 10,
   parameter int DISPLAY = DEF_H_DISPLAY,
   parameter int FRONT   = DEF_H_FRONT,
   parameter int SYNC    = DEF_H_SYNC,
   parameter int BACK    = DEF_H_BACK
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         advance,
   input  logic         load,
   input  logic [W-1:0] new_display,
   input  logic [W-1:0] new_front,
   input  logic [W-1:0] new_sync,
   input  logic [W-1:0] new_back,
   output logic [W-1:0] pos,
   output logic         wrap,
   output logic         sync_next,
   output logic         visible_next
);

   localparam logic [W:0] ONE       = (W+1)'(1);
   localparam logic [W:0] DEF_TOTAL = (W+1)'(DISPLAY + FRONT + SYNC + BACK);

   logic [W-1:0] pos_q, pos_d;
   logic [W-1:0] display_q, display_d;
   logic [W-1:0] front_q, front_d;
   logic [W-1:0] sync_len_q, sync_len_d;
   logic [W-1:0] back_q, back_d;
   logic [W:0]   total;
   logic [W:0]   sync_lo;
   logic [W:0]   sync_hi;

   always_comb begin
      total = {1'b0, display_q} + {1'b0, front_q} + {1'b0, sync_len_q} + {1'b0, back_q};
      wrap  = advance && ({1'b0, pos_q} == total - ONE);
      pos_d = pos_q;
      if (advance) begin
         pos_d = wrap ? '0 : pos_q + W'(1);
      end
      // A new config only ever lands on a wrap, so decoding with it covers position 0 onward.
      display_d  = load ? new_display : display_q;
      front_d    = load ? new_front   : front_q;
      sync_len_d = load ? new_sync    : sync_len_q;
      back_d     = load ? new_back    : back_q;
      sync_lo      = {1'b0, display_d} + {1'b0, front_d};
      sync_hi      = sync_lo + {1'b0, sync_len_d};
      sync_next    = ({1'b0, pos_d} >= sync_lo) && ({1'b0, pos_d} < sync_hi);
      visible_next = pos_d < display_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos_q      <= W'(DEF_TOTAL - ONE);
         display_q  <= W'(DISPLAY);
         front_q    <= W'(FRONT);
         sync_len_q <= W'(SYNC);
         back_q     <= W'(BACK);
      end else begin
         pos_q      <= pos_d;
         display_q  <= display_d;
         front_q    <= front_d;
         sync_len_q <= sync_len_d;
         back_q     <= back_d;
      end
   end

   assign pos = pos_q;

endmodule

// File: rtl/video_timing_defs.vh
// rtl/video_timing_defs.vh - default display timing shared by the generator, renderers and benches
`ifndef VIDEO_TIMING_DEFS_VH
`define VIDEO_TIMING_DEFS_VH

`define VTG_H_DISPLAY 256
`define VTG_H_FRONT   7
`define VTG_H_SYNC    23
`define VTG_H_BACK    23

`define VTG_V_DISPLAY 240
`define VTG_V_BOTTOM  14
`define VTG_V_SYNC    3
`define VTG_V_TOP     5

`define VTG_TOTAL(d, f, s, b) ((d) + (f) + (s) + (b))

`endif

// File: rtl/video_timing_generator.sv
// rtl/video_timing_generator.sv - sync, visibility, strobes and frame count for one display channel
// New timing is held pending and swapped in on the frame wrap so a frame never mixes timings.
module video_timing_generator
   import video_timing_pkg::*;
#(
   parameter int HW         = 10,
   parameter int VW         = 10,
   parameter int FRAME_W    = 8,
   parameter int H_DISPLAY  = DEF_H_DISPLAY,
   parameter int H_FRONT    = DEF_H_FRONT,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BACK     = DEF_H_BACK,
   parameter int V_DISPLAY  = DEF_V_DISPLAY,
   parameter int V_BOTTOM   = DEF_V_BOTTOM,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_TOP      = DEF_V_TOP,
   parameter bit H_SYNC_POL = DEF_H_SYNC_POL,
   parameter bit V_SYNC_POL = DEF_V_SYNC_POL
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [HW-1:0]      cfg_h_display,
   input  logic [HW-1:0]      cfg_h_front,
   input  logic [HW-1:0]      cfg_h_sync,
   input  logic [HW-1:0]      cfg_h_back,
   input  logic [VW-1:0]      cfg_v_display,
   input  logic [VW-1:0]      cfg_v_bottom,
   input  logic [VW-1:0]      cfg_v_sync,
   input  logic [VW-1:0]      cfg_v_top,
   output logic [HW-1:0]      hpos,
   output logic [VW-1:0]      vpos,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_count
);

   logic h_wrap, v_wrap, h_sync_next, h_vis_next, v_sync_next, v_vis_next;
   logic handshake, frame_wrap, apply;

   logic                  pend_valid_q, pend_valid_d;
   logic [3:0][HW-1:0]    pend_h_q, pend_h_d;
   logic [3:0][VW-1:0]    pend_v_q, pend_v_d;
   logic                  cfg_ready_q, cfg_ready_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   logic                  display_on_q, display_on_d;
   logic                  line_start_q, line_start_d;
   logic                  frame_start_q, frame_start_d;
   logic [FRAME_W-1:0]    frame_count_q, frame_count_d;

   video_timing_axis #(
      .W(HW), .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h_axis (
      .clk(clk), .reset(reset), .advance(enable), .load(apply),
      .new_display(pend_h_q[0]), .new_front(pend_h_q[1]),
      .new_sync(pend_h_q[2]), .new_back(pend_h_q[3]),
      .pos(hpos), .wrap(h_wrap), .sync_next(h_sync_next), .visible_next(h_vis_next)
   );

   video_timing_axis #(
      .W(VW), .DISPLAY(V_DISPLAY), .FRONT(V_BOTTOM), .SYNC(V_SYNC), .BACK(V_TOP)
   ) u_v_axis (
      .clk(clk), .reset(reset), .advance(h_wrap), .load(apply),
      .new_display(pend_v_q[0]), .new_front(pend_v_q[1]),
      .new_sync(pend_v_q[2]), .new_back(pend_v_q[3]),
      .pos(vpos), .wrap(v_wrap), .sync_next(v_sync_next), .visible_next(v_vis_next)
   );

   always_comb begin
      handshake  = cfg_valid && cfg_ready_q;
      frame_wrap = h_wrap && v_wrap;
      // A capture on the wrap cycle sees pend_valid_q low, so it waits for the next wrap.
      apply      = frame_wrap && pend_valid_q;

      pend_valid_d = pend_valid_q;
      pend_h_d     = pend_h_q;
      pend_v_d     = pend_v_q;
      if (apply) begin
         pend_valid_d = 1'b0;
      end
      if (handshake) begin
         pend_valid_d = 1'b1;
         pend_h_d     = {cfg_h_back, cfg_h_sync, cfg_h_front, cfg_h_display};
         pend_v_d     = {cfg_v_top, cfg_v_sync, cfg_v_bottom, cfg_v_display};
      end
      cfg_ready_d = !pend_valid_d;

      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      display_on_d  = display_on_q;
      frame_count_d = frame_count_q;
      line_start_d  = h_wrap;
      frame_start_d = frame_wrap;
      if (enable) begin
         hsync_d      = h_sync_next ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_d      = v_sync_next ? V_SYNC_POL : ~V_SYNC_POL;
         display_on_d = h_vis_next && v_vis_next;
      end
      if (frame_wrap) begin
         frame_count_d = frame_count_q + FRAME_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_valid_q  <= 1'b0;
         pend_h_q      <= '0;
         pend_v_q      <= '0;
         cfg_ready_q   <= 1'b1;
         hsync_q       <= ~H_SYNC_POL;
         vsync_q       <= ~V_SYNC_POL;
         display_on_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '1;
      end else begin
         pend_valid_q  <= pend_valid_d;
         pend_h_q      <= pend_h_d;
         pend_v_q      <= pend_v_d;
         cfg_ready_q   <= cfg_ready_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = display_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// tb/tb_video_timing_generator.sv - randomized bench against a pixel-grid reference model
module tb_video_timing_generator;

   localparam int  HD = 8, HF = 1, HS = 2, HB = 1;
   localparam int  VD = 6, VB = 1, VS = 1, VT = 1;
   localparam bit  HPOL = 1'b0;
   localparam bit  VPOL = 1'b1;
   localparam int  NCYC = 40000;
   localparam int  RST1 = 30000;
   localparam int  RST2 = 36000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [9:0] cfg_h_display, cfg_h_front, cfg_h_sync, cfg_h_back;
   logic [9:0] cfg_v_display, cfg_v_bottom, cfg_v_sync, cfg_v_top;
   logic [9:0] hpos, vpos;
   logic       hsync, vsync, display_on, line_start, frame_start;
   logic [7:0] frame_count;

   always #5 clk = ~clk;

   video_timing_generator #(
      .HW(10), .VW(10), .FRAME_W(8),
      .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
      .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_h_display(cfg_h_display), .cfg_h_front(cfg_h_front),
      .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
      .cfg_v_display(cfg_v_display), .cfg_v_bottom(cfg_v_bottom),
      .cfg_v_sync(cfg_v_sync), .cfg_v_top(cfg_v_top),
      .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
      .display_on(display_on), .line_start(line_start),
      .frame_start(frame_start), .frame_count(frame_count)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: pixel grid position, timing tables and expected outputs.
   int hcfg[4], vcfg[4], hpend[4], vpend[4];
   bit pend;
   int hp, vp, fc;
   bit e_hsync, e_vsync, e_disp, e_ls, e_fs;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int total4(input int c[4]);
      return c[0] + c[1] + c[2] + c[3];
   endfunction

   function automatic bit in_sync(input int p, input int c[4]);
      return (p >= c[0] + c[1]) && (p < c[0] + c[1] + c[2]);
   endfunction

   task automatic model_reset();
      hcfg = '{HD, HF, HS, HB};
      vcfg = '{VD, VB, VS, VT};
      pend = 1'b0;
      hp = total4(hcfg) - 1;
      vp = total4(vcfg) - 1;
      fc = 255;
      e_hsync = !HPOL;
      e_vsync = !VPOL;
      e_disp = 1'b0;
      e_ls = 1'b0;
      e_fs = 1'b0;
   endtask

   task automatic model_step();
      bit fire;
      bit fwrap;
      fire = cfg_valid && !pend;
      fwrap = 1'b0;
      e_ls = 1'b0;
      e_fs = 1'b0;
      if (enable) begin
         hp++;
         if (hp >= total4(hcfg)) begin
            hp = 0;
            vp++;
            if (vp >= total4(vcfg)) begin
               vp = 0;
               fwrap = 1'b1;
            end
         end
         if (fwrap) begin
            fc = (fc + 1) % 256;
            if (pend) begin
               hcfg = hpend;
               vcfg = vpend;
               pend = 1'b0;
            end
         end
         e_ls = (hp == 0);
         e_fs = (hp == 0) && (vp == 0);
         e_hsync = in_sync(hp, hcfg) ? HPOL : !HPOL;
         e_vsync = in_sync(vp, vcfg) ? VPOL : !VPOL;
         e_disp = (hp < hcfg[0]) && (vp < vcfg[0]);
      end
      if (fire) begin
         hpend = '{int'(cfg_h_display), int'(cfg_h_front), int'(cfg_h_sync), int'(cfg_h_back)};
         vpend = '{int'(cfg_v_display), int'(cfg_v_bottom), int'(cfg_v_sync), int'(cfg_v_top)};
         pend = 1'b1;
      end
   endtask

   task automatic check_all();
      expect_eq("hpos", 32'(hpos), 32'(hp));
      expect_eq("vpos", 32'(vpos), 32'(vp));
      expect_eq("hsync", 32'(hsync), 32'(e_hsync));
      expect_eq("vsync", 32'(vsync), 32'(e_vsync));
      expect_eq("display_on", 32'(display_on), 32'(e_disp));
      expect_eq("line_start", 32'(line_start), 32'(e_ls));
      expect_eq("frame_start", 32'(frame_start), 32'(e_fs));
      expect_eq("frame_count", 32'(frame_count), 32'(fc));
      expect_eq("cfg_ready", 32'(cfg_ready), 32'(!pend));
   endtask

   task automatic randomize_cfg();
      cfg_h_display = 10'($urandom_range(1, 6));
      cfg_h_front   = 10'($urandom_range(0, 2));
      cfg_h_sync    = 10'($urandom_range(0, 2));
      cfg_h_back    = 10'($urandom_range(0, 2));
      cfg_v_display = 10'($urandom_range(1, 5));
      cfg_v_bottom  = 10'($urandom_range(0, 2));
      cfg_v_sync    = 10'($urandom_range(0, 2));
      cfg_v_top     = 10'($urandom_range(0, 2));
   endtask

   initial begin
      bit wrap_soon;
      randomize_cfg();
      #1 reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b1;
      enable = 1'b1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         if (reset) model_step();
         #1;
         check_all();
         enable = (cyc >= 2000 && cyc < 2010) ? 1'b0 : ($urandom_range(0, 9) != 0);
         randomize_cfg();
         wrap_soon = enable && (hp + 1 >= total4(hcfg)) && (vp + 1 >= total4(vcfg));
         cfg_valid = wrap_soon ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
         if (cyc == RST1 - 1 || cyc == RST2 - 1) cfg_valid = 1'b1;
         if (cyc == RST1 || cyc == RST2) begin
            #2 reset = 1'b0;
            #1;
            model_reset();
            check_all();
         end
         if (cyc == RST1 + 3 || cyc == RST2 + 3) begin
            #3 reset = 1'b1;
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
